sync_fifo: RTL
==============

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8: data word width in bits.
REQ-002 The block SHALL provide parameter POINTER, default 4: address width; DEPTH = 2^POINTER words.
REQ-003 The block SHALL provide parameter ALMOST_FULL, default 12: level at or above which wr_almost_full asserts.
REQ-004 The block SHALL provide parameter ALMOST_EMPTY, default 4: level at or below which rd_almost_empty asserts.
REQ-005 The block SHALL provide parameter FWFT, default 1: 1 = first-word-fall-through read; 0 = registered read with one-cycle latency.
REQ-006 Ports SHALL be:
  clk              in   1          single clock; all logic on its rising edge
  sresetn          in   1          synchronous reset, active-low
  flush            in   1          synchronous clear of FIFO state
  wren             in   1          write request
  data_in          in   WIDTH      write data
  wr_full          out  1          level == DEPTH
  wr_almost_full   out  1          level >= ALMOST_FULL
  rden             in   1          read request
  data_out         out  WIDTH      read data
  rd_empty         out  1          level == 0
  rd_almost_empty  out  1          level <= ALMOST_EMPTY
  level            out  POINTER+1  current occupancy, 0..DEPTH
  overflow         out  1          sticky: write attempted while full
  underflow        out  1          sticky: read attempted while empty
REQ-007 The block SHALL use one clock, with reset synchronous and active-low on sresetn.

Function
REQ-008 Write accept SHALL be wren && !wr_full; an accepted write stores data_in at wr_ptr and increments wr_ptr.
REQ-009 Read accept SHALL be rden && !rd_empty; an accepted read increments rd_ptr.
REQ-010 The read and write pointers SHALL be POINTER+1 bits wide, with the MSB serving as the wrap bit; full = low bits equal and MSB different; empty = pointers equal.
REQ-011 Pointers SHALL wrap modulo 2^(POINTER+1) with no special case at the DEPTH boundary.
REQ-012 level SHALL be a registered counter: +1 on write-only accept, -1 on read-only accept, unchanged when both or neither are accepted.
REQ-013 Flags SHALL derive from the current registered state, so a write while full SHALL be rejected even if a read is accepted in the same cycle.
REQ-014 When empty with both wren and rden high, the write SHALL be accepted and the read rejected, and underflow SHALL set.
REQ-015 With FWFT=1, data_out SHALL equal mem[rd_ptr] combinationally and be valid whenever rd_empty==0; a word written into an empty FIFO SHALL appear the cycle after the write, with rd_empty deasserting in that same cycle.
REQ-016 With FWFT=0, data_out SHALL be a register loaded with mem[rd_ptr] on an accepted read, valid the cycle after the accept, and held otherwise.
REQ-017 overflow SHALL set on wren && wr_full, and underflow SHALL set on rden && rd_empty; both SHALL hold until reset or flush.
REQ-018 flush SHALL, on the next edge, zero both pointers, level, overflow and underflow; flush SHALL take priority over wren and rden in the same cycle, and memory contents SHALL NOT be cleared.
REQ-019 wr_almost_full and rd_almost_empty SHALL be compares against the registered level, with no extra latency.
REQ-020 ALMOST_FULL SHALL lie in 1..DEPTH and ALMOST_EMPTY in 0..DEPTH-1; the design is not required to handle values outside these ranges.

Reset
REQ-021 On a clk edge with sresetn==0, the block SHALL apply: wr_ptr=0, rd_ptr=0, level=0, overflow=0, underflow=0, and the FWFT=0 data_out register=0.
REQ-022 Out of reset, outputs SHALL read: rd_empty=1, rd_almost_empty=1, wr_full=0, wr_almost_full=0.
REQ-023 Reset asserted mid-operation SHALL discard all stored words, and no accept SHALL occur in the reset cycle.
REQ-024 Memory SHALL NOT be reset.

Verification
REQ-025 Fill test: after reset, write 0x00..0x0F on 16 consecutive cycles -> level=16, wr_full=1, wr_almost_full=1 from level 12; a 17th write sets overflow=1 with level still 16.
REQ-026 Drain test: from full, read 16 cycles -> data_out sequence 0x00..0x0F in order (FWFT=1 and FWFT=0 shifted by one cycle); then rd_empty=1, and one more rden sets underflow=1.
REQ-027 Wrap test: run 40 writes interleaved with reads, keeping level between 3 and 5 -> pointers wrap twice, with no data loss or reorder and flags consistent with level.
REQ-028 Simultaneous test: at level=16, drive wren and rden together -> read accepted, write rejected, level=15, overflow=1; at level=0, drive both -> level=1, underflow=1.
REQ-029 Flush/reset test: at level=7 with overflow=1, assert flush together with wren -> next cycle level=0, rd_empty=1, overflow=0, nothing written; repeat with sresetn=0 -> same result.

Source files
------------

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo -- single-clock FIFO with occupancy counter, almost flags and
// sticky overflow/underflow indicators.
//
// Parameters
//   WIDTH         data word width in bits
//   POINTER       address width; DEPTH = 2**POINTER words
//   ALMOST_FULL   level at or above which wr_almost_full asserts (1..DEPTH)
//   ALMOST_EMPTY  level at or below which rd_almost_empty asserts (0..DEPTH-1)
//   FWFT          1 = first-word-fall-through read, 0 = registered read
//
// Ports
//   clk              rising-edge clock for all logic
//   sresetn          synchronous reset, active-low
//   flush            synchronous clear of pointers, level and sticky flags
//   wren, data_in    write request and data
//   wr_full          level == DEPTH
//   wr_almost_full   level >= ALMOST_FULL
//   rden             read request
//   data_out         read data (combinational if FWFT=1, registered if FWFT=0)
//   rd_empty         level == 0
//   rd_almost_empty  level <= ALMOST_EMPTY
//   level            current occupancy, 0..DEPTH
//   overflow         sticky: write attempted while full
//   underflow        sticky: read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH        = 8,
    parameter int POINTER      = 4,
    parameter int ALMOST_FULL  = 12,
    parameter int ALMOST_EMPTY = 4,
    parameter int FWFT         = 1
) (
    input  logic               clk,
    input  logic               sresetn,
    input  logic               flush,
    input  logic               wren,
    input  logic [WIDTH-1:0]   data_in,
    output logic               wr_full,
    output logic               wr_almost_full,
    input  logic               rden,
    output logic [WIDTH-1:0]   data_out,
    output logic               rd_empty,
    output logic               rd_almost_empty,
    output logic [POINTER:0]   level,
    output logic               overflow,
    output logic               underflow
);

    localparam int DEPTH = 1 << POINTER;

    localparam logic [POINTER:0] AF_LVL = ALMOST_FULL[POINTER:0];
    localparam logic [POINTER:0] AE_LVL = ALMOST_EMPTY[POINTER:0];
    localparam logic [POINTER:0] ONE    = {{POINTER{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];

    // Extra MSB on each pointer is the wrap bit: it separates full from empty
    // when the address bits coincide.
    logic [POINTER:0] wr_ptr;
    logic [POINTER:0] rd_ptr;

    logic wr_accept;
    logic rd_accept;
    logic mem_we;

    // Flags come only from registered state, so a read in the same cycle
    // cannot make room for a write to a full FIFO.
    assign wr_full  = (wr_ptr[POINTER] != rd_ptr[POINTER]) &&
                      (wr_ptr[POINTER-1:0] == rd_ptr[POINTER-1:0]);
    assign rd_empty = (wr_ptr == rd_ptr);

    assign wr_almost_full  = (level >= AF_LVL);
    assign rd_almost_empty = (level <= AE_LVL);

    assign wr_accept = wren && !wr_full;
    assign rd_accept = rden && !rd_empty;

    // Reset and flush both outrank a write, so the array is never touched in
    // those cycles.
    assign mem_we = wr_accept && sresetn && !flush;

    // NOTE: storage has no reset; stale words are unreachable once the
    // pointers are cleared, and leaving the array unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr[POINTER-1:0]] <= data_in;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + ONE;
            end
            // Simultaneous accepts leave the occupancy unchanged.
            if (wr_accept && !rd_accept) begin
                level <= level + ONE;
            end else if (rd_accept && !wr_accept) begin
                level <= level - ONE;
            end
            if (wren && wr_full) begin
                overflow <= 1'b1;
            end
            if (rden && rd_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is visible as soon as it is stored.
            assign data_out = mem[rd_ptr[POINTER-1:0]];
        end else begin : g_registered
            logic [WIDTH-1:0] data_q;

            always_ff @(posedge clk) begin
                if (!sresetn) begin
                    data_q <= '0;
                end else if (rd_accept && !flush) begin
                    data_q <= mem[rd_ptr[POINTER-1:0]];
                end
            end

            assign data_out = data_q;
        end
    endgenerate

endmodule
